// File: rtl/calc2_port_sched.sv
// Per-port request scheduler for one calc2 request port: tag allocation, the
// two-beat issue sequence, response matching and timeout retirement.
module calc2_port_sched #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    output logic [3:0]  port_cmd,
    output logic [31:0] port_data,
    output logic [1:0]  port_tag,
    input  logic [1:0]  out_resp,
    input  logic [1:0]  out_tag,
    input  logic [31:0] out_data,
    output logic        cpl_valid,
    output logic [1:0]  cpl_tag,
    output logic [3:0]  cpl_cmd,
    output logic [1:0]  cpl_resp,
    output logic [31:0] cpl_data,
    output logic        cpl_timeout,
    output logic        tag_err,
    output logic [2:0]  outstanding
);

    typedef enum logic [1:0] {IDLE, OP1, OP2} state_t;

    // A tag retires on the edge where its count would reach TIMEOUT_CYCLES,
    // so the strobe appears exactly TIMEOUT_CYCLES edges after acceptance.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] TMO_SAT  = 8'(TIMEOUT_CYCLES);

    state_t      state, state_next;
    logic [3:0]  busy;
    logic [3:0]  cmd_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [1:0]  tag_q;
    logic [3:0]  tag_cmd [4];
    logic [7:0]  cnt [4];

    logic        accept;
    logic [1:0]  alloc_tag;
    logic [3:0]  alloc_mask;
    logic [3:0]  free_mask;
    logic [3:0]  eligible;
    logic        resp_hit;
    logic        tmo_fire;
    logic [1:0]  tmo_tag;

    assign req_ready = !reset && (state == IDLE || state == OP2) && !(&busy);
    assign accept    = req_valid && req_ready;
    assign resp_hit  = (out_resp != 2'd0) && busy[out_tag];
    assign tmo_fire  = |eligible;

    assign outstanding = {2'b00, busy[0]} + {2'b00, busy[1]}
                       + {2'b00, busy[2]} + {2'b00, busy[3]};

    always_comb begin
        alloc_tag = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!busy[i]) alloc_tag = 2'(i);
        end
    end

    always_comb begin
        eligible = 4'b0000;
        tmo_tag  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            eligible[i] = busy[i] && (cnt[i] >= TMO_LAST);
        end
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) tmo_tag = 2'(i);
        end
    end

    // A DUV response always takes the single completion slot ahead of timeouts.
    always_comb begin
        free_mask  = 4'b0000;
        alloc_mask = 4'b0000;
        if (resp_hit) begin
            free_mask[out_tag] = 1'b1;
        end else if (tmo_fire) begin
            free_mask[tmo_tag] = 1'b1;
        end
        if (accept) begin
            alloc_mask[alloc_tag] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = OP1;
            OP1:     state_next = OP2;
            OP2:     state_next = accept ? OP1 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        port_cmd  = 4'd0;
        port_data = 32'd0;
        port_tag  = 2'd0;
        case (state)
            OP1: begin
                port_cmd  = cmd_q;
                port_data = op1_q;
                port_tag  = tag_q;
            end
            OP2: begin
                port_data = op2_q;
                port_tag  = tag_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 4'b0000;
            cmd_q       <= 4'd0;
            op1_q       <= 32'd0;
            op2_q       <= 32'd0;
            tag_q       <= 2'd0;
            cpl_valid   <= 1'b0;
            cpl_tag     <= 2'd0;
            cpl_cmd     <= 4'd0;
            cpl_resp    <= 2'd0;
            cpl_data    <= 32'd0;
            cpl_timeout <= 1'b0;
            tag_err     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt[i]     <= 8'd0;
                tag_cmd[i] <= 4'd0;
            end
        end else begin
            state <= state_next;
            busy  <= (busy & ~free_mask) | alloc_mask;

            for (int i = 0; i < 4; i++) begin
                if (alloc_mask[i] || free_mask[i]) begin
                    cnt[i] <= 8'd0;
                end else if (busy[i] && cnt[i] != TMO_SAT) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end

            if (accept) begin
                cmd_q              <= req_cmd;
                op1_q              <= req_op1;
                op2_q              <= req_op2;
                tag_q              <= alloc_tag;
                tag_cmd[alloc_tag] <= req_cmd;
            end

            tag_err   <= (out_resp != 2'd0) && !busy[out_tag];
            cpl_valid <= resp_hit || tmo_fire;
            if (resp_hit) begin
                cpl_tag     <= out_tag;
                cpl_cmd     <= tag_cmd[out_tag];
                cpl_resp    <= (out_resp == 2'd3) ? 2'd2 : out_resp;
                cpl_data    <= out_data;
                cpl_timeout <= 1'b0;
            end else if (tmo_fire) begin
                cpl_tag     <= tmo_tag;
                cpl_cmd     <= tag_cmd[tmo_tag];
                cpl_resp    <= 2'd0;
                cpl_data    <= 32'd0;
                cpl_timeout <= 1'b1;
            end else begin
                cpl_tag     <= 2'd0;
                cpl_cmd     <= 4'd0;
                cpl_resp    <= 2'd0;
                cpl_data    <= 32'd0;
                cpl_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_calc2_port_sched.sv
// Self-checking bench for calc2_port_sched: directed scenarios followed by a
// random phase, all checked against a transaction-level reference model.
module tb_calc2_port_sched;

    localparam int TMO = 8;

    logic        c_clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic [3:0]  port_cmd;
    logic [31:0] port_data;
    logic [1:0]  port_tag;
    logic [1:0]  out_resp;
    logic [1:0]  out_tag;
    logic [31:0] out_data;
    logic        cpl_valid;
    logic [1:0]  cpl_tag;
    logic [3:0]  cpl_cmd;
    logic [1:0]  cpl_resp;
    logic [31:0] cpl_data;
    logic        cpl_timeout;
    logic        tag_err;
    logic [2:0]  outstanding;

    calc2_port_sched #(.TIMEOUT_CYCLES(TMO)) dut (
        .c_clk(c_clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
        .port_cmd(port_cmd), .port_data(port_data), .port_tag(port_tag),
        .out_resp(out_resp), .out_tag(out_tag), .out_data(out_data),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_cmd(cpl_cmd),
        .cpl_resp(cpl_resp), .cpl_data(cpl_data), .cpl_timeout(cpl_timeout),
        .tag_err(tag_err), .outstanding(outstanding)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    int total = 0;
    int bad   = 0;
    bit armed = 0;

    // Reference model: tag table with ages plus a queue of port beats still to
    // appear on the DUV port, one beat per cycle.
    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] data;
        logic [1:0]  tag;
    } beat_t;

    beat_t       beats[$];
    bit          m_busy [4];
    int          m_age  [4];
    logic [3:0]  m_cmd  [4];

    logic        e_valid;
    logic [1:0]  e_tag;
    logic [3:0]  e_cmd;
    logic [1:0]  e_resp;
    logic [31:0] e_data;
    logic        e_timeout;
    logic        e_tag_err;

    logic [3:0]  cmds [4];

    task automatic checkOutput(input string name, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] c,
                                 input logic [31:0] a, input logic [31:0] b);
        req_valid = v;
        req_cmd   = c;
        req_op1   = a;
        req_op2   = b;
    endtask

    task automatic applyResponse(input logic [1:0] r, input logic [1:0] t,
                                 input logic [31:0] d);
        out_resp = r;
        out_tag  = t;
        out_data = d;
    endtask

    function automatic bit modelReady();
        bit any_free = 0;
        for (int t = 0; t < 4; t++) if (!m_busy[t]) any_free = 1;
        return !reset && (beats.size() <= 1) && any_free;
    endfunction

    function automatic int modelCount();
        int n = 0;
        for (int t = 0; t < 4; t++) if (m_busy[t]) n++;
        return n;
    endfunction

    // One clock: check combinational outputs, cross the edge, advance the
    // model with the inputs that were sampled, then check registered outputs.
    task automatic step();
        bit          acc;
        bit          was_reset;
        int          ft;
        int          freed;
        logic [31:0] exp_cmd, exp_data, exp_tag;
        #1;
        if (armed) begin
            exp_cmd  = (beats.size() > 0) ? 32'(beats[0].cmd)  : 32'd0;
            exp_data = (beats.size() > 0) ? beats[0].data      : 32'd0;
            exp_tag  = (beats.size() > 0) ? 32'(beats[0].tag)  : 32'd0;
            checkOutput("req_ready",   32'(req_ready),   32'(modelReady()));
            checkOutput("port_cmd",    32'(port_cmd),    exp_cmd);
            checkOutput("port_data",   port_data,        exp_data);
            checkOutput("port_tag",    32'(port_tag),    exp_tag);
            checkOutput("outstanding", 32'(outstanding), 32'(modelCount()));
        end
        @(posedge c_clk);
        #1;
        was_reset = reset;
        e_valid = 0; e_tag = 0; e_cmd = 0; e_resp = 0; e_data = 0;
        e_timeout = 0; e_tag_err = 0;
        if (reset) begin
            beats.delete();
            for (int t = 0; t < 4; t++) begin
                m_busy[t] = 0;
                m_age[t]  = 0;
            end
            armed = 1;
        end else begin
            acc = req_valid && modelReady();
            ft = 0;
            for (int t = 3; t >= 0; t--) if (!m_busy[t]) ft = t;
            freed = -1;
            if (out_resp != 0 && m_busy[out_tag]) begin
                e_valid = 1;
                e_tag   = out_tag;
                e_cmd   = m_cmd[out_tag];
                e_resp  = (out_resp == 2'd3) ? 2'd2 : out_resp;
                e_data  = out_data;
                freed   = int'(out_tag);
            end else begin
                for (int t = 0; t < 4; t++) begin
                    if (freed < 0 && m_busy[t] && m_age[t] + 1 >= TMO) begin
                        e_valid   = 1;
                        e_tag     = 2'(t);
                        e_cmd     = m_cmd[t];
                        e_timeout = 1;
                        freed     = t;
                    end
                end
            end
            e_tag_err = (out_resp != 0) && !m_busy[out_tag];
            if (freed >= 0) m_busy[freed] = 0;
            for (int t = 0; t < 4; t++) if (m_busy[t]) m_age[t]++;
            if (beats.size() > 0) void'(beats.pop_front());
            if (acc) begin
                m_busy[ft] = 1;
                m_age[ft]  = 0;
                m_cmd[ft]  = req_cmd;
                beats.push_back('{cmd: req_cmd, data: req_op1, tag: 2'(ft)});
                beats.push_back('{cmd: 4'd0,    data: req_op2, tag: 2'(ft)});
            end
        end
        if (armed) begin
            checkOutput("cpl_valid", 32'(cpl_valid), 32'(e_valid));
            checkOutput("tag_err",   32'(tag_err),   32'(e_tag_err));
            if (e_valid || was_reset) begin
                checkOutput("cpl_tag",     32'(cpl_tag),     32'(e_tag));
                checkOutput("cpl_cmd",     32'(cpl_cmd),     32'(e_cmd));
                checkOutput("cpl_resp",    32'(cpl_resp),    32'(e_resp));
                checkOutput("cpl_data",    cpl_data,         e_data);
                checkOutput("cpl_timeout", 32'(cpl_timeout), 32'(e_timeout));
            end
        end
    endtask

    task automatic drain(input int n);
        applyStimulus(0, 4'd0, 32'd0, 32'd0);
        applyResponse(2'd0, 2'd0, 32'd0);
        repeat (n) step();
    endtask

    // Safety net so the run always ends even if something stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] d;
        cmds[0] = 4'd2; cmds[1] = 4'd5; cmds[2] = 4'd6; cmds[3] = 4'd1;
        reset = 1'b1;
        applyStimulus(0, 4'd0, 32'd0, 32'd0);
        applyResponse(2'd0, 2'd0, 32'd0);

        $display("[TB] reset");
        step();
        step();
        checkOutput("rst_ready", 32'(req_ready),   32'd0);
        checkOutput("rst_outst", 32'(outstanding), 32'd0);
        checkOutput("rst_pcmd",  32'(port_cmd),    32'd0);
        reset = 1'b0;
        step();

        $display("[TB] single add");
        applyStimulus(1, 4'd1, 32'h0000_0005, 32'h0000_0003);
        step();
        applyStimulus(0, 4'd0, 32'd0, 32'd0);
        checkOutput("add_op1_cmd",  32'(port_cmd), 32'd1);
        checkOutput("add_op1_data", port_data,     32'd5);
        checkOutput("add_op1_tag",  32'(port_tag), 32'd0);
        step();
        checkOutput("add_op2_cmd",  32'(port_cmd), 32'd0);
        checkOutput("add_op2_data", port_data,     32'd3);
        applyResponse(2'd1, 2'd0, 32'd8);
        step();
        checkOutput("add_cpl_valid", 32'(cpl_valid),   32'd1);
        checkOutput("add_cpl_cmd",   32'(cpl_cmd),     32'd1);
        checkOutput("add_cpl_data",  cpl_data,         32'd8);
        checkOutput("add_outst",     32'(outstanding), 32'd0);
        drain(2);

        $display("[TB] tag exhaustion");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, cmds[i], $urandom, $urandom);
            step();
            checkOutput("exh_tag", 32'(port_tag), 32'(i));
            checkOutput("exh_cmd", 32'(port_cmd), 32'(cmds[i]));
            if (i < 3) step();
        end
        applyStimulus(0, 4'd0, 32'd0, 32'd0);
        applyResponse(2'd1, 2'd2, $urandom);
        checkOutput("exh_ready_full", 32'(req_ready),   32'd0);
        checkOutput("exh_outst_full", 32'(outstanding), 32'd4);
        step();
        checkOutput("exh_cpl_tag", 32'(cpl_tag),   32'd2);
        checkOutput("exh_reready", 32'(req_ready), 32'd1);
        applyResponse(2'd0, 2'd0, 32'd0);
        applyStimulus(1, 4'd3, $urandom, $urandom);
        step();
        checkOutput("exh_reuse_tag", 32'(port_tag),    32'd2);
        checkOutput("exh_tmo_tag0",  32'(cpl_timeout), 32'd1);
        drain(14);

        $display("[TB] out-of-order completion");
        applyStimulus(1, 4'd1, $urandom, $urandom);
        step();
        step();
        applyStimulus(1, 4'd2, $urandom, $urandom);
        step();
        applyStimulus(0, 4'd0, 32'd0, 32'd0);
        d = $urandom;
        applyResponse(2'd2, 2'd1, d);
        step();
        checkOutput("ooo_t1_tag",  32'(cpl_tag),  32'd1);
        checkOutput("ooo_t1_cmd",  32'(cpl_cmd),  32'd2);
        checkOutput("ooo_t1_resp", 32'(cpl_resp), 32'd2);
        d = $urandom;
        applyResponse(2'd1, 2'd0, d);
        step();
        checkOutput("ooo_t0_tag",  32'(cpl_tag), 32'd0);
        checkOutput("ooo_t0_cmd",  32'(cpl_cmd), 32'd1);
        checkOutput("ooo_t0_data", cpl_data,     d);
        applyResponse(2'd0, 2'd0, 32'd0);
        applyStimulus(1, 4'd6, $urandom, $urandom);
        step();
        applyStimulus(0, 4'd0, 32'd0, 32'd0);
        step();
        applyResponse(2'd3, 2'd0, $urandom);
        step();
        checkOutput("ooo_resp3", 32'(cpl_resp), 32'd2);
        checkOutput("ooo_cmd6",  32'(cpl_cmd),  32'd6);
        drain(14);

        $display("[TB] timeout");
        applyStimulus(1, 4'd5, $urandom, $urandom);
        step();
        applyStimulus(0, 4'd0, 32'd0, 32'd0);
        for (int k = 1; k < TMO; k++) begin
            step();
            checkOutput("tmo_early", 32'(cpl_valid), 32'd0);
        end
        step();
        checkOutput("tmo_valid", 32'(cpl_valid),   32'd1);
        checkOutput("tmo_flag",  32'(cpl_timeout), 32'd1);
        checkOutput("tmo_resp",  32'(cpl_resp),    32'd0);
        checkOutput("tmo_data",  cpl_data,         32'd0);
        checkOutput("tmo_outst", 32'(outstanding), 32'd0);
        applyResponse(2'd1, 2'd0, $urandom);
        step();
        checkOutput("tmo_late_err", 32'(tag_err),   32'd1);
        checkOutput("tmo_late_cpl", 32'(cpl_valid), 32'd0);
        drain(3);

        $display("[TB] response/timeout collision");
        applyStimulus(1, 4'd1, $urandom, $urandom);
        step();
        applyStimulus(1, 4'd2, $urandom, $urandom);
        step();
        step();
        applyStimulus(0, 4'd0, 32'd0, 32'd0);
        applyResponse(2'd1, 2'd0, $urandom);
        step();
        applyResponse(2'd0, 2'd0, 32'd0);
        applyStimulus(1, 4'd6, $urandom, $urandom);
        step();
        checkOutput("col_realloc", 32'(port_tag), 32'd0);
        applyStimulus(0, 4'd0, 32'd0, 32'd0);
        repeat (5) step();
        applyResponse(2'd1, 2'd0, $urandom);
        step();
        checkOutput("col_first_tag", 32'(cpl_tag),     32'd0);
        checkOutput("col_first_tmo", 32'(cpl_timeout), 32'd0);
        applyResponse(2'd0, 2'd0, 32'd0);
        step();
        checkOutput("col_second_tag", 32'(cpl_tag),     32'd1);
        checkOutput("col_second_tmo", 32'(cpl_timeout), 32'd1);
        drain(14);

        $display("[TB] reset during OP2");
        applyStimulus(1, 4'd1, $urandom, $urandom);
        step();
        step();
        step();
        applyStimulus(0, 4'd0, 32'd0, 32'd0);
        step();
        checkOutput("rop2_outst_pre", 32'(outstanding), 32'd2);
        reset = 1'b1;
        applyStimulus(1, 4'd2, $urandom, $urandom);
        step();
        checkOutput("rop2_pcmd",  32'(port_cmd),    32'd0);
        checkOutput("rop2_pdata", port_data,        32'd0);
        checkOutput("rop2_ptag",  32'(port_tag),    32'd0);
        checkOutput("rop2_outst", 32'(outstanding), 32'd0);
        checkOutput("rop2_cpl",   32'(cpl_valid),   32'd0);
        reset = 1'b0;
        applyStimulus(0, 4'd0, 32'd0, 32'd0);
        #1;
        checkOutput("rop2_ready", 32'(req_ready), 32'd1);
        drain(3);

        $display("[TB] random phase");
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            applyStimulus($urandom_range(0, 1) == 1, 4'($urandom), $urandom, $urandom);
            if ($urandom_range(0, 9) < 4)
                applyResponse(2'($urandom_range(1, 3)), 2'($urandom), $urandom);
            else
                applyResponse(2'd0, 2'($urandom), $urandom);
            step();
        end
        reset = 1'b0;
        drain(14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
